// File: rtl/st_packets_to_bytes_enc_pkg.sv
// Shared byte-stream framing constants and encoder FSM encodings; the
// byte-to-packet decoder imports this package for the same special bytes.
package st_packets_to_bytes_enc_pkg;

  localparam logic [7:0] SOP_BYTE  = 8'h7A;
  localparam logic [7:0] EOP_BYTE  = 8'h7B;
  localparam logic [7:0] CHAN_BYTE = 8'h7C;
  localparam logic [7:0] ESC_BYTE  = 8'h7D;
  localparam logic [7:0] ESC_MASK  = 8'h20;

  // Each state names the byte currently presented on out_data.
  typedef enum logic [2:0] {
    ST_IDLE, ST_CHAN, ST_CHAN_ESC, ST_CHAN_VAL,
    ST_SOP, ST_EOP, ST_DATA_ESC, ST_DATA
  } enc_state_t;

  typedef struct packed {
    logic [7:0] data;
    logic [7:0] chan;
    logic       sop;
    logic       eop;
    logic       hdr;
  } beat_t;

  function automatic logic is_special(logic [7:0] b);
    return (b >= SOP_BYTE) && (b <= ESC_BYTE);
  endfunction

  // Byte sequence of one beat: CHAN [ESC] chan, SOP, EOP, [ESC] data.
  // Steps over any element the beat does not need.
  function automatic enc_state_t next_state(enc_state_t cur, logic hdr,
                                            logic chan_esc, logic sop,
                                            logic eop, logic data_esc);
    enc_state_t data_st, eop_st, sop_st, n;
    data_st = data_esc ? ST_DATA_ESC : ST_DATA;
    eop_st  = eop ? ST_EOP : data_st;
    sop_st  = sop ? ST_SOP : eop_st;
    case (cur)
      ST_IDLE:     n = hdr ? ST_CHAN : sop_st;
      ST_CHAN:     n = chan_esc ? ST_CHAN_ESC : ST_CHAN_VAL;
      ST_CHAN_ESC: n = ST_CHAN_VAL;
      ST_CHAN_VAL: n = sop_st;
      ST_SOP:      n = eop_st;
      ST_EOP:      n = data_st;
      ST_DATA_ESC: n = ST_DATA;
      default:     n = ST_IDLE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/st_byte_escape.sv
// Combinational escape check: flags framing bytes and returns the byte that
// follows ESC on the wire (original byte when no escape is needed).
module st_byte_escape
  import st_packets_to_bytes_enc_pkg::*;
(
  input  logic [7:0] byte_in,
  output logic       needs_esc,
  output logic [7:0] byte_out
);

  assign needs_esc = is_special(byte_in);
  assign byte_out  = needs_esc ? (byte_in ^ ESC_MASK) : byte_in;

endmodule

// File: rtl/st_packets_to_bytes_enc.sv
// Avalon-ST packet to byte-stream encoder: frames each beat with optional
// channel header, SOP/EOP markers and escapes, one registered byte per cycle.
module st_packets_to_bytes_enc
  import st_packets_to_bytes_enc_pkg::*;
#(
  parameter bit CHAN_ON_EVERY_SOP = 1'b0,
  parameter bit SEND_CHANNEL      = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  output logic       in_ready,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic [7:0] in_channel,
  input  logic       in_startofpacket,
  input  logic       in_endofpacket,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_data
);

  enc_state_t state, state_nxt;
  beat_t      cap, cur;
  logic       chan_sent;
  logic [7:0] last_chan;
  logic       accept, advance, final_byte, hdr_due;
  logic       chan_needs_esc, data_needs_esc;
  logic [7:0] chan_enc, data_enc, byte_nxt;

  assign advance    = out_valid && out_ready;
  assign final_byte = (state == ST_DATA);
  // Ready on the last byte's handshake lets the next beat follow with no bubble.
  assign in_ready   = !reset && ((state == ST_IDLE) || (advance && final_byte));
  assign accept     = in_valid && in_ready;
  assign hdr_due    = SEND_CHANNEL &&
                      (!chan_sent || (in_channel != last_chan) ||
                       (CHAN_ON_EVERY_SOP && in_startofpacket));

  // The beat being sequenced: the incoming one on accept, else the captured one.
  always_comb begin
    cur = cap;
    if (accept) begin
      cur.data = in_data;
      cur.chan = in_channel;
      cur.sop  = in_startofpacket;
      cur.eop  = in_endofpacket;
      cur.hdr  = hdr_due;
    end
  end

  st_byte_escape u_chan_esc (
    .byte_in   (cur.chan),
    .needs_esc (chan_needs_esc),
    .byte_out  (chan_enc)
  );

  st_byte_escape u_data_esc (
    .byte_in   (cur.data),
    .needs_esc (data_needs_esc),
    .byte_out  (data_enc)
  );

  always_comb begin
    state_nxt = state;
    if (accept || advance)
      state_nxt = next_state(accept ? ST_IDLE : state, cur.hdr, chan_needs_esc,
                             cur.sop, cur.eop, data_needs_esc);
  end

  always_comb begin
    byte_nxt = 8'h00;
    case (state_nxt)
      ST_CHAN:     byte_nxt = CHAN_BYTE;
      ST_CHAN_ESC: byte_nxt = ESC_BYTE;
      ST_CHAN_VAL: byte_nxt = chan_enc;
      ST_SOP:      byte_nxt = SOP_BYTE;
      ST_EOP:      byte_nxt = EOP_BYTE;
      ST_DATA_ESC: byte_nxt = ESC_BYTE;
      ST_DATA:     byte_nxt = data_enc;
      default:     byte_nxt = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      cap       <= '0;
      chan_sent <= 1'b0;
      last_chan <= 8'h00;
    end else begin
      state <= state_nxt;
      if (accept || advance) begin
        out_valid <= (state_nxt != ST_IDLE);
        if (state_nxt != ST_IDLE) out_data <= byte_nxt;
      end
      if (accept) cap <= cur;
      // The channel only counts as sent once its value byte leaves the block.
      if (advance && (state == ST_CHAN_VAL)) begin
        last_chan <= cap.chan;
        chan_sent <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_st_packets_to_bytes_enc.sv
// Scoreboard bench: a beat-level framing model queues expected bytes on each
// accepted beat; a monitor pops and compares every transferred output byte.
module tb_st_packets_to_bytes_enc;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0, rst = 1'b1;
  logic       iv0 = 1'b0, isop0 = 1'b0, ieop0 = 1'b0, ordy0 = 1'b1;
  logic [7:0] ich0 = 8'h00, idat0 = 8'h00;
  logic       in_ready0, ov0;
  logic [7:0] od0;
  logic       iv1 = 1'b0, isop1 = 1'b0, ieop1 = 1'b0, ordy1 = 1'b1;
  logic [7:0] ich1 = 8'h00, idat1 = 8'h00;
  logic       in_ready1, ov1;
  logic [7:0] od1;

  int  nvec = 0, nerr = 0, cyc = 0, rx_n = 0, last_cyc = 0, acc_cyc = 0;
  bq_t exp0, exp1, fx;
  bit  m_sent[2];
  logic [7:0] m_last[2];
  bit  m_ces[2];
  bit  rnd_rdy = 1'b0;
  logic [7:0] chset[6];

  st_packets_to_bytes_enc dut0 (
    .clk(clk), .reset(rst), .in_ready(in_ready0), .in_valid(iv0),
    .in_data(idat0), .in_channel(ich0), .in_startofpacket(isop0),
    .in_endofpacket(ieop0), .out_ready(ordy0), .out_valid(ov0), .out_data(od0)
  );

  st_packets_to_bytes_enc #(.CHAN_ON_EVERY_SOP(1'b1)) dut1 (
    .clk(clk), .reset(rst), .in_ready(in_ready1), .in_valid(iv1),
    .in_data(idat1), .in_channel(ich1), .in_startofpacket(isop1),
    .in_endofpacket(ieop1), .out_ready(ordy1), .out_valid(ov1), .out_data(od1)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  initial forever begin
    @(posedge clk); #1;
    ordy0 = rnd_rdy ? ($urandom_range(0, 9) < 3) : 1'b1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int expv);
    nvec++;
    if (act != expv) begin
      nerr++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", nm, act, act, expv, expv);
    end
  endtask

  task automatic add_byte(inout bq_t q, input logic [7:0] b);
    if (b >= 8'h7A && b <= 8'h7D) begin
      q.push_back(8'h7D);
      q.push_back(b ^ 8'h20);
    end else q.push_back(b);
  endtask

  // Framing rules applied per beat; channel state lives per DUT.
  task automatic model_beat(input int id, input logic [7:0] ch, input logic [7:0] d,
                            input bit s, input bit e, output bq_t q);
    q.delete();
    if (!m_sent[id] || ch != m_last[id] || (m_ces[id] && s)) begin
      q.push_back(8'h7C);
      add_byte(q, ch);
      m_sent[id] = 1'b1;
      m_last[id] = ch;
    end
    if (s) q.push_back(8'h7A);
    if (e) q.push_back(8'h7B);
    add_byte(q, d);
  endtask

  task automatic send(input int id, input logic [7:0] ch, input logic [7:0] d,
                      input bit s, input bit e);
    bq_t q;
    bit ok = 1'b0;
    model_beat(id, ch, d, s, e, q);
    if (fx.size() > 0) q = fx;
    fx.delete();
    if (id == 0) begin iv0 = 1'b1; ich0 = ch; idat0 = d; isop0 = s; ieop0 = e; end
    else         begin iv1 = 1'b1; ich1 = ch; idat1 = d; isop1 = s; ieop1 = e; end
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if ((id == 0) ? in_ready0 : in_ready1) begin
        ok = 1'b1;
        acc_cyc = cyc;
        foreach (q[k]) begin
          if (id == 0) exp0.push_back(q[k]); else exp1.push_back(q[k]);
        end
        break;
      end
    end
    if (!ok) begin
      nvec++; nerr++;
      $display("FAIL accept_timeout dut%0d: in_ready stayed 0, required 1", id);
    end
    @(posedge clk); #1;
    if (id == 0) iv0 = 1'b0; else iv1 = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 3000; i++) begin
      if (exp0.size() == 0 && exp1.size() == 0) break;
      @(posedge clk);
    end
    #1;
    chk("drain_pending_bytes", exp0.size() + exp1.size(), 0);
  endtask

  // Monitor: every transferred byte must be the next expected one, and a
  // stalled byte must still be on the bus the following cycle.
  initial begin
    logic [7:0] ev, held0;
    bit st0;
    st0 = 1'b0; held0 = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) st0 = 1'b0;
      else begin
        if (st0) begin
          nvec++;
          if (!ov0 || od0 !== held0) begin
            nerr++;
            $display("FAIL stall_hold: valid=%0b data=%h, required 1/%h", ov0, od0, held0);
          end
        end
        if (ov0 && ordy0) begin
          nvec++;
          if (exp0.size() == 0) begin
            nerr++;
            $display("FAIL unexpected_byte dut0: got %h, required none", od0);
          end else begin
            ev = exp0.pop_front();
            if (od0 !== ev) begin
              nerr++;
              $display("FAIL byte dut0: got %h, required %h", od0, ev);
            end
          end
          rx_n++;
          last_cyc = cyc;
        end
        st0 = ov0 && !ordy0;
        held0 = od0;
        if (ov1 && ordy1) begin
          nvec++;
          if (exp1.size() == 0) begin
            nerr++;
            $display("FAIL unexpected_byte dut1: got %h, required none", od1);
          end else begin
            ev = exp1.pop_front();
            if (od1 !== ev) begin
              nerr++;
              $display("FAIL byte dut1: got %h, required %h", od1, ev);
            end
          end
        end
      end
    end
  end

  initial begin
    int first, base, len;
    logic [7:0] ch, d;
    chset = '{8'h00, 8'h01, 8'h7A, 8'h7B, 8'h7C, 8'h7D};
    m_ces[0] = 1'b0; m_ces[1] = 1'b1;
    for (int i = 0; i < 2; i++) begin m_sent[i] = 1'b0; m_last[i] = 8'h00; end

    repeat (3) @(posedge clk); #1;
    chk("reset_out_valid", int'(ov0), 0);
    chk("reset_out_data", int'(od0), 0);
    chk("reset_in_ready", int'(in_ready0), 0);
    chk("reset_out_valid_ces", int'(ov1), 0);
    rst = 1'b0; #1;
    chk("ready_after_reset", int'(in_ready0), 1);
    @(posedge clk); #1;

    // Directed beats back to back with out_ready high: 16 bytes, no gaps.
    fx = {8'h7C, 8'h00, 8'h7A, 8'h7B, 8'h41}; send(0, 8'h00, 8'h41, 1'b1, 1'b1);
    first = acc_cyc;
    fx = {8'h7A, 8'h11}; send(0, 8'h00, 8'h11, 1'b1, 1'b0);
    fx = {8'h7B, 8'h22}; send(0, 8'h00, 8'h22, 1'b0, 1'b1);
    fx = {8'h7C, 8'h7D, 8'h5C, 8'h7A, 8'h7B, 8'h7D, 8'h5D};
    send(0, 8'h7C, 8'h7D, 1'b1, 1'b1);
    drain();
    chk("latency_throughput_cycles", last_cyc - first, 16);

    // Reset after the second byte of a five-byte beat.
    @(posedge clk); #1;
    base = rx_n;
    fx = {8'h7C, 8'h05, 8'h7A, 8'h7B, 8'h41}; send(0, 8'h05, 8'h41, 1'b1, 1'b1);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      if (rx_n >= base + 2) break;
    end
    #1; rst = 1'b1;
    exp0.delete(); exp1.delete();
    for (int i = 0; i < 2; i++) begin m_sent[i] = 1'b0; m_last[i] = 8'h00; end
    #1;
    chk("midreset_out_valid", int'(ov0), 0);
    chk("midreset_in_ready", int'(in_ready0), 0);
    @(posedge clk); #1; rst = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("no_residual_valid", int'(ov0), 0);
    chk("bytes_before_reset", rx_n - base, 2);
    fx = {8'h7C, 8'h05, 8'h7A, 8'h7B, 8'h41}; send(0, 8'h05, 8'h41, 1'b1, 1'b1);
    drain();

    // Random packets against the model with out_ready ~30% high.
    rnd_rdy = 1'b1;
    for (int p = 0; p < 100; p++) begin
      len = $urandom_range(1, 4);
      ch = chset[$urandom_range(0, 5)];
      for (int b = 0; b < len; b++) begin
        d = ($urandom_range(0, 3) == 0) ? 8'h7A + 8'($urandom_range(0, 3))
                                        : 8'($urandom);
        send(0, ch, d, b == 0, b == len - 1);
      end
    end
    drain();
    rnd_rdy = 1'b0;

    // Channel header on every SOP, even with an unchanged channel.
    fx = {8'h7C, 8'h03, 8'h7A, 8'h10}; send(1, 8'h03, 8'h10, 1'b1, 1'b0);
    fx = {8'h7B, 8'h11};               send(1, 8'h03, 8'h11, 1'b0, 1'b1);
    fx = {8'h7C, 8'h03, 8'h7A, 8'h20}; send(1, 8'h03, 8'h20, 1'b1, 1'b0);
    fx = {8'h7B, 8'h21};               send(1, 8'h03, 8'h21, 1'b0, 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/st_packets_to_bytes_enc.md
ST_PACKETS_TO_BYTES_ENC -- requirements
Module: st_packets_to_bytes_enc

Interface
REQ-001 SHALL have parameter CHAN_ON_EVERY_SOP, default 0, meaning 1 = emit channel header on every SOP beat, not only on channel change.
REQ-002 SHALL have parameter SEND_CHANNEL, default 1, meaning 0 = never emit channel headers (in_channel ignored).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_ready  output  1  sink ready (Avalon-ST, readyLatency 0).
REQ-006 SHALL have port in_valid  input  1  source beat valid.
REQ-007 SHALL have port in_data  input  8  packet payload byte.
REQ-008 SHALL have port in_channel  input  8  packet channel number.
REQ-009 SHALL have port in_startofpacket  input  1  first beat of packet.
REQ-010 SHALL have port in_endofpacket  input  1  last beat of packet.
REQ-011 SHALL have port out_ready  input  1  byte-stream sink ready (readyLatency 0).
REQ-012 SHALL have port out_valid  output  1  encoded byte valid, registered.
REQ-013 SHALL have port out_data  output  8  encoded byte, registered.

Function
REQ-014 SHALL use special bytes SOP=0x7A, EOP=0x7B, CHAN=0x7C, ESC=0x7D; any payload or channel byte in 0x7A..0x7D SHALL be sent as ESC followed by byte XOR 0x20.
REQ-015 SHALL accept an input beat on clk when in_valid && in_ready, capturing data, channel, SOP, EOP.
REQ-016 SHALL emit per accepted beat, in order: [CHAN, channel (escaped if special)] if header due; SOP if in_startofpacket; EOP if in_endofpacket; data (escaped if special).
REQ-017 SHALL consider channel header due when SEND_CHANNEL=1 and (no channel sent since reset, or in_channel != last sent channel, or CHAN_ON_EVERY_SOP=1 and in_startofpacket).
REQ-018 SHALL update last-sent-channel register when the channel byte is accepted downstream.
REQ-019 SHALL sequence bytes with FSM states IDLE, CHAN, CHAN_ESC, CHAN_VAL, SOP, EOP, DATA_ESC, DATA; the state names the byte currently on out_data; unneeded states are skipped.
REQ-020 SHALL advance to the next byte only on out_valid && out_ready; out_data/out_valid SHALL be stable while out_valid && !out_ready.
REQ-021 SHALL drive in_ready = 1 in IDLE, or when the final byte of the current beat is accepted this cycle (back-to-back beats, no bubble).
REQ-022 SHALL present first byte of an accepted beat on out_data the cycle after acceptance (latency 1).
REQ-023 SHALL sustain 1 byte/cycle with out_ready held high; worst case 7 bytes per beat.
REQ-024 SHALL not drop, reorder or duplicate bytes under any out_ready pattern.
REQ-025 SHALL treat beat with both SOP and EOP as single-byte packet: SOP then EOP then data.

Reset
REQ-026 SHALL on reset assert: out_valid=0, out_data=0x00, FSM=IDLE, channel-sent flag=0, last channel=0x00, captured beat cleared.
REQ-027 SHALL abandon any partially emitted beat on reset mid-sequence; no residual bytes after deassertion.
REQ-028 SHALL drive in_ready=0 while reset asserted.

Structure
REQ-029 SHALL place special byte constants (0x7A..0x7D), escape mask 0x20 and FSM state encodings in a shared package used also by the byte-to-packet decoder.
REQ-030 SHALL implement escape detection/XOR as sub-module st_byte_escape (combinational: byte in -> needs_esc, escaped byte out), instantiated for channel and data.

Verification
REQ-031 SHALL test: single beat ch=0x00 data=0x41 SOP=EOP=1, out_ready=1 -> 0x7C,0x00,0x7A,0x7B,0x41 on consecutive cycles.
REQ-032 SHALL test: second packet same ch=0x00, data 0x11,0x22 -> 0x7A,0x11,0x7B,0x22 (no channel header).
REQ-033 SHALL test: ch=0x7C data=0x7D SOP=EOP=1 -> 0x7C,0x7D,0x5C,0x7A,0x7B,0x7D,0x5D.
REQ-034 SHALL test: out_ready toggled random 30% high over 100 random packets -> decoded stream equals input packets, out_data stable while stalled.
REQ-035 SHALL test: reset asserted after 2nd byte of 5-byte sequence -> out_valid=0 immediately; next beat on same channel re-sends channel header.
REQ-036 SHALL test: CHAN_ON_EVERY_SOP=1, two packets ch=0x03 -> each begins 0x7C,0x03,0x7A.
